dsp_file_responder: RTL and testbench

Target end of the DSP equation file interface. It services the file_num / file_read / file_write requests issued by the equation engines. It holds NUM_FILES independent word FIFOs ("files") in internal storage and answers each request with a busy/complete handshake on file_active and returned data on file_read_data. It sits beside the equations top-level and is the block that the equation engines' file port connects to.

---
 rtl/dsp_file_responder.sv | 151 +++++++++++++++
 tb/tb_dsp_file_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_file_responder.sv
`default_nettype none
// ============================================================================
// Module      : dsp_file_responder
// Description : Target of the DSP equation file port.
//               Services file_read / file_write requests against NUM_FILES
//               independent word FIFOs, using a busy/complete handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_file_responder #(
    parameter int NUM_FILES     = 4,
    parameter int DEPTH         = 64,
    parameter int ACCESS_CYCLES = 2,
    parameter int DW            = 32
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [7:0]           file_num,
    input  logic                 file_read,
    input  logic                 file_write,
    input  logic [DW-1:0]        file_write_data,
    output logic [DW-1:0]        file_read_data,
    output logic                 file_active,
    output logic                 file_error,
    output logic [NUM_FILES-1:0] file_empty,
    output logic [NUM_FILES-1:0] file_full
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_FW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
    localparam int c_CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    localparam logic [7:0]      c_NUM_FILES = 8'(NUM_FILES);
    localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_ONE       = (c_AW + 1)'(1);
    localparam logic [c_CW-1:0] c_CNT_LOAD  = c_CW'(ACCESS_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [7:0]             r_file;
    logic                   r_op_rd;
    logic                   r_op_wr;
    logic [DW-1:0]          r_data;
    logic                   r_active;
    logic                   r_error;
    logic [DW-1:0]          r_rd_data;
    logic [NUM_FILES-1:0]   r_empty;
    logic [NUM_FILES-1:0]   r_full;
    logic [c_AW-1:0]        r_rd_ptr [NUM_FILES];
    logic [c_AW-1:0]        r_wr_ptr [NUM_FILES];
    logic [c_AW:0]          r_count  [NUM_FILES];
    logic [DW-1:0]          r_mem    [NUM_FILES*DEPTH];

    logic [c_FW-1:0]        w_idx;
    logic                   w_valid;
    logic                   w_done;
    logic                   w_do_rd;
    logic                   w_do_wr;
    logic                   w_err;
    logic [c_FW+c_AW-1:0]   w_rd_addr;
    logic [c_FW+c_AW-1:0]   w_wr_addr;

    assign w_idx     = r_file[c_FW-1:0];
    assign w_valid   = (r_file < c_NUM_FILES);
    assign w_done    = (r_state == S_BUSY) && (r_cnt == '0);
    // A simultaneous read+write request is never serviced, only flagged.
    assign w_do_rd   = w_done && r_op_rd && !r_op_wr && w_valid && (r_count[w_idx] != '0);
    assign w_do_wr   = w_done && r_op_wr && !r_op_rd && w_valid && (r_count[w_idx] != c_DEPTH);
    assign w_err     = w_done && !w_do_rd && !w_do_wr;
    assign w_rd_addr = {w_idx, r_rd_ptr[w_idx]};
    assign w_wr_addr = {w_idx, r_wr_ptr[w_idx]};

    // Storage is deliberately left out of reset.
    always_ff @(posedge wb_clk) begin
        if (w_do_wr) begin
            r_mem[w_wr_addr] <= r_data;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_file    <= '0;
            r_op_rd   <= 1'b0;
            r_op_wr   <= 1'b0;
            r_data    <= '0;
            r_active  <= 1'b0;
            r_error   <= 1'b0;
            r_rd_data <= '0;
            r_empty   <= '1;
            r_full    <= '0;
            for (int i = 0; i < NUM_FILES; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (file_read || file_write) begin
                        r_file   <= file_num;
                        r_op_rd  <= file_read;
                        r_op_wr  <= file_write;
                        r_data   <= file_write_data;
                        r_cnt    <= c_CNT_LOAD;
                        r_active <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_active <= 1'b0;
                        r_state  <= S_IDLE;
                        r_error  <= w_err;
                        if (w_do_rd) begin
                            r_rd_data       <= r_mem[w_rd_addr];
                            r_rd_ptr[w_idx] <= r_rd_ptr[w_idx] + 1'b1;
                            r_count[w_idx]  <= r_count[w_idx] - 1'b1;
                            r_empty[w_idx]  <= (r_count[w_idx] == c_ONE);
                            r_full[w_idx]   <= 1'b0;
                        end else if (w_do_wr) begin
                            r_wr_ptr[w_idx] <= r_wr_ptr[w_idx] + 1'b1;
                            r_count[w_idx]  <= r_count[w_idx] + 1'b1;
                            r_full[w_idx]   <= (r_count[w_idx] == c_DEPTH - c_ONE);
                            r_empty[w_idx]  <= 1'b0;
                        end else if (r_op_rd && !r_op_wr) begin
                            r_rd_data <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign file_read_data = r_rd_data;
    assign file_active    = r_active;
    assign file_error     = r_error;
    assign file_empty     = r_empty;
    assign file_full      = r_full;

endmodule
`default_nettype wire

// File: tb/tb_dsp_file_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_file_responder
// Description : Directed bench with a per-file queue model and read-data
//               scoreboard for dsp_file_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_file_responder;

    localparam int NF    = 4;
    localparam int DEPTH = 64;
    localparam int AC    = 2;
    localparam int DW    = 32;

    logic          wb_clk = 1'b0;
    logic          wb_rst;
    logic [7:0]    file_num;
    logic          file_read;
    logic          file_write;
    logic [DW-1:0] file_write_data;
    logic [DW-1:0] file_read_data;
    logic          file_active;
    logic          file_error;
    logic [NF-1:0] file_empty;
    logic [NF-1:0] file_full;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model [NF][$];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] last_rd = '0;

    dsp_file_responder #(
        .NUM_FILES    (NF),
        .DEPTH        (DEPTH),
        .ACCESS_CYCLES(AC),
        .DW           (DW)
    ) dut (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .file_num       (file_num),
        .file_read      (file_read),
        .file_write     (file_write),
        .file_write_data(file_write_data),
        .file_read_data (file_read_data),
        .file_active    (file_active),
        .file_error     (file_error),
        .file_empty     (file_empty),
        .file_full      (file_full)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NF-1:0] exp_empty();
        logic [NF-1:0] e;
        for (int i = 0; i < NF; i++) e[i] = (model[i].size() == 0);
        return e;
    endfunction

    function automatic logic [NF-1:0] exp_full();
        logic [NF-1:0] f;
        for (int i = 0; i < NF; i++) f[i] = (model[i].size() == DEPTH);
        return f;
    endfunction

    // Called one step after the accept edge; returns cycles file_active was seen high.
    task automatic wait_done(output int n);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge wb_clk); #1;
            if (!file_active) break;
            n++;
        end
    endtask

    task automatic do_op(input logic [7:0] num, input logic rd, input logic wr,
                         input logic [DW-1:0] data, input string tag);
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        int            n;
        int            idx;
        idx = int'(num);
        @(negedge wb_clk);
        file_num        = num;
        file_read       = rd;
        file_write      = wr;
        file_write_data = data;
        exp_err = 1'b0;
        if (rd && wr) begin
            exp_err = 1'b1;
        end else if (idx >= NF) begin
            exp_err = 1'b1;
            if (rd) last_rd = '0;
        end else if (rd) begin
            if (model[idx].size() == 0) begin
                exp_err = 1'b1;
                last_rd = '0;
            end else begin
                last_rd = model[idx].pop_front();
            end
        end else if (model[idx].size() == DEPTH) begin
            exp_err = 1'b1;
        end else begin
            model[idx].push_back(data);
        end
        sb_q.push_back(last_rd);
        @(posedge wb_clk); #1;
        file_read  = 1'b0;
        file_write = 1'b0;
        check({tag, " active"}, 64'(file_active), 64'(1));
        wait_done(n);
        check({tag, " cycles"}, 64'(n), 64'(AC));
        check({tag, " error"}, 64'(file_error), 64'(exp_err));
        exp_rd = sb_q.pop_front();
        check({tag, " rdata"}, 64'(file_read_data), 64'(exp_rd));
        check({tag, " empty"}, 64'(file_empty), 64'(exp_empty()));
        check({tag, " full"}, 64'(file_full), 64'(exp_full()));
        @(posedge wb_clk); #1;
        check({tag, " err_clr"}, 64'(file_error), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            n;
        int            gap;
        logic [DW-1:0] exp_rd;
        wb_rst          = 1'b0;
        file_num        = '0;
        file_read       = 1'b0;
        file_write      = 1'b0;
        file_write_data = '0;

        // Reset then idle
        repeat (2) @(posedge wb_clk);
        #1;
        check("rst active", 64'(file_active), 64'(0));
        check("rst rdata", 64'(file_read_data), 64'(0));
        check("rst empty", 64'(file_empty), 64'(4'b1111));
        check("rst full", 64'(file_full), 64'(4'b0000));
        check("rst error", 64'(file_error), 64'(0));
        @(negedge wb_clk);
        wb_rst = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1;
        check("idle active", 64'(file_active), 64'(0));
        check("idle empty", 64'(file_empty), 64'(4'b1111));
        check("idle rdata", 64'(file_read_data), 64'(0));

        // Write then read
        do_op(8'd1, 1'b0, 1'b1, 32'hDEADBEEF, "wr1");
        do_op(8'd1, 1'b1, 1'b0, 32'h0, "rd1");
        check("rd1 value", 64'(file_read_data), 64'(32'hDEADBEEF));

        // Fill, overflow, drain, wrap
        for (int i = 0; i < DEPTH; i++) do_op(8'd0, 1'b0, 1'b1, 32'(i), "fill");
        check("full0", 64'(file_full[0]), 64'(1));
        do_op(8'd0, 1'b0, 1'b1, 32'hBAD0BAD0, "ovf");
        for (int i = 0; i < DEPTH; i++) do_op(8'd0, 1'b1, 1'b0, 32'h0, "drain");
        for (int i = 0; i < 5; i++) do_op(8'd0, 1'b0, 1'b1, 32'h100 + 32'(i), "wrap_wr");
        for (int i = 0; i < 5; i++) do_op(8'd0, 1'b1, 1'b0, 32'h0, "wrap_rd");

        // Empty and illegal requests
        do_op(8'd2, 1'b1, 1'b0, 32'h0, "rd_empty");
        do_op(8'd7, 1'b0, 1'b1, 32'h1234, "bad_wr");
        do_op(8'd7, 1'b1, 1'b0, 32'h0, "bad_rd");
        do_op(8'd1, 1'b0, 1'b1, 32'h5555, "pre1");
        do_op(8'd1, 1'b1, 1'b1, 32'h7777, "both");
        do_op(8'd1, 1'b1, 1'b0, 32'h0, "post1");

        // Held request and isolation
        do_op(8'd0, 1'b0, 1'b1, 32'hA0A0, "iso0");
        for (int i = 0; i < 3; i++) do_op(8'd3, 1'b0, 1'b1, 32'hC300 + 32'(i), "pre3");
        @(negedge wb_clk);
        file_num  = 8'd3;
        file_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            while (!file_active && gap < 10) begin
                @(posedge wb_clk); #1;
                gap++;
            end
            if (k > 0) check("held gap", 64'(gap), 64'(1));
            sb_q.push_back(model[3].pop_front());
            wait_done(n);
            if (k == 2) file_read = 1'b0;
            check("held cycles", 64'(n), 64'(AC));
            check("held error", 64'(file_error), 64'(0));
            exp_rd = sb_q.pop_front();
            check("held rdata", 64'(file_read_data), 64'(exp_rd));
        end
        repeat (2) @(posedge wb_clk);
        #1;
        check("held stop", 64'(file_active), 64'(0));
        check("held empty", 64'(file_empty), 64'(exp_empty()));
        check("held full", 64'(file_full), 64'(exp_full()));

        // Reset mid-transaction
        @(negedge wb_clk);
        file_num        = 8'd2;
        file_write      = 1'b1;
        file_write_data = 32'hFEEDF00D;
        @(posedge wb_clk); #1;
        file_write = 1'b0;
        check("mid active", 64'(file_active), 64'(1));
        #1;
        wb_rst = 1'b0;
        #1;
        check("mid drop", 64'(file_active), 64'(0));
        check("mid err", 64'(file_error), 64'(0));
        for (int i = 0; i < NF; i++) model[i].delete();
        last_rd = '0;
        @(negedge wb_clk);
        wb_rst = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1;
        check("post rst empty0", 64'(file_empty[0]), 64'(1));
        check("post rst empty", 64'(file_empty), 64'(exp_empty()));
        check("post rst err", 64'(file_error), 64'(0));
        check("post rst active", 64'(file_active), 64'(0));
        do_op(8'd2, 1'b1, 1'b0, 32'h0, "post_rst_rd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
